// File: rtl/iob_reset_seq_pkg.sv
// Shared types and constants for the sequenced board reset generator.
// Holds the state encoding and the width constants used by the top-level FSM.
package iob_reset_seq_pkg;

   localparam int STATE_W       = 2;
   localparam int RESTART_CNT_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_HOLD       = 2'd0,
      ST_WAIT_READY = 2'd1,
      ST_RELEASE    = 2'd2,
      ST_RUN        = 2'd3
   } state_e;

   // Used to size the shared phase counter for the longest of the three phases.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/iob_sync_n.sv
// N-bit two-flop synchroniser for asynchronous level inputs.
// Both stages reset to 0, so nothing reads as "ready" until it has really been seen.
module iob_sync_n #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // NOTE: clocked state uses non-blocking assignments so that both stages
   // sample their inputs at the same edge and the two-cycle delay is preserved.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/iob_reset_seq.sv
// Sequenced reset generator: holds all channels in reset, waits for stable readys,
// then releases channels in order; re-sequences on ready loss or a restart request.
module iob_reset_seq
   import iob_reset_seq_pkg::*;
#(
   parameter int N_CH          = 3,
   parameter int N_READY       = 2,
   parameter int HOLD_CYCLES   = 10,
   parameter int STABLE_CYCLES = 4,
   parameter int STEP_CYCLES   = 3
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [N_READY-1:0]       ready_i,
   input  logic                     restart_i,
   output logic [N_CH-1:0]          rst_o,
   output logic                     done_o,
   output logic [STATE_W-1:0]       state_o,
   output logic [RESTART_CNT_W-1:0] restart_cnt_o
);

   localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STABLE_CYCLES, STEP_CYCLES) + 1);
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_CH - 1);

   state_e                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic [IDX_W-1:0]         idx, idx_nxt;
   logic [N_CH-1:0]          rst_q, rst_nxt;
   logic                     done_q, done_nxt;
   logic [RESTART_CNT_W-1:0] rcnt, rcnt_nxt;

   logic [N_READY-1:0] rdy_sync;
   logic               rdy_s;
   logic               resequence;

   iob_sync_n #(
      .W (N_READY)
   ) u_ready_sync (
      .clk    (clk_i),
      .arst_n (arst_n_i),
      .d      (ready_i),
      .q      (rdy_sync)
   );

   assign rdy_s = &rdy_sync;

   // Entry to RELEASE requires rdy_s high, so a low rdy_s here is always a fall.
   assign resequence = ((state == ST_RELEASE) || (state == ST_RUN)) && (!rdy_s || restart_i);

   // NOTE: every output of this block gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      rst_nxt   = rst_q;
      done_nxt  = 1'b0;
      rcnt_nxt  = rcnt;

      if (resequence) begin
         // Takes priority over a step release due in the same cycle.
         state_nxt = ST_HOLD;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         rst_nxt   = '1;
         if (rcnt != '1) rcnt_nxt = rcnt + 1'b1;
      end else begin
         unique case (state)
            ST_HOLD: begin
               rst_nxt = '1;
               if (restart_i) begin
                  cnt_nxt = '0;
               end else if (cnt == HOLD_LAST) begin
                  state_nxt = ST_WAIT_READY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end

            ST_WAIT_READY: begin
               if (restart_i || !rdy_s) begin
                  cnt_nxt = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nxt = ST_RELEASE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end

            ST_RELEASE: begin
               if (cnt == STEP_LAST) begin
                  rst_nxt[idx] = 1'b0;
                  cnt_nxt      = '0;
                  if (idx == IDX_LAST) begin
                     state_nxt = ST_RUN;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end

            ST_RUN: begin
               done_nxt = 1'b1;
            end

            default: begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               rst_nxt   = '1;
            end
         endcase
      end
   end

   // NOTE: every flop, including the restart counter, takes its reset value
   // asynchronously so the outputs are safe before the first clock edge.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state  <= ST_HOLD;
         cnt    <= '0;
         idx    <= '0;
         rst_q  <= '1;
         done_q <= 1'b0;
         rcnt   <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         rst_q  <= rst_nxt;
         done_q <= done_nxt;
         rcnt   <= rcnt_nxt;
      end
   end

   assign rst_o         = rst_q;
   assign done_o        = done_q;
   assign state_o       = state;
   assign restart_cnt_o = rcnt;

endmodule
